// File: rtl/mux4_rr_arbiter.sv
// Four-input round-robin mux arbiter. It hands ownership of a 4:1 mux to one
// requester at a time and puts a one-cycle break-before-make gap between owners.
module mux4_rr_arbiter #(
  parameter int HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] grant,
  output logic       s1,
  output logic       s0,
  output logic       valid,
  output logic       preempt
);

  localparam int CW = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] HOLD_LIM = CW'(HOLD_MAX);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t        state_reg, state_next;
  logic [1:0]    owner_reg, owner_next;
  logic [1:0]    lw_reg, lw_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [3:0]    grant_reg, grant_next;
  logic [1:0]    sel_reg, sel_next;
  logic          valid_reg, valid_next;
  logic          preempt_reg, preempt_next;

  logic [3:0]    rot_req;
  logic [1:0]    win_ofs;
  logic [1:0]    winner;
  logic          timeout;

  // rot_req[k] is the request that sits k+1 places after the last winner.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rot
      localparam logic [1:0] OFS = 2'(gi + 1);
      assign rot_req[gi] = req[lw_reg + OFS];
    end
  endgenerate

  always_comb begin
    win_ofs = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (rot_req[k]) win_ofs = 2'(k);
    end
  end

  assign winner  = lw_reg + 2'd1 + win_ofs;
  assign timeout = (HOLD_MAX != 0) && (cnt_reg == HOLD_LIM);

  always_comb begin
    state_next   = state_reg;
    owner_next   = owner_reg;
    lw_next      = lw_reg;
    cnt_next     = cnt_reg;
    preempt_next = 1'b0;
    case (state_reg)
      IDLE, GAP: begin
        if (|req) begin
          state_next = GRANT;
          owner_next = winner;
          lw_next    = winner;
          cnt_next   = CW'(1);
        end else begin
          state_next = IDLE;
        end
      end
      GRANT: begin
        if (done || !req[owner_reg] || timeout) begin
          state_next   = GAP;
          // Only a forced release is a preemption; a voluntary one is not.
          preempt_next = timeout && !done && req[owner_reg];
        end else if (cnt_reg != CNT_MAX) begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so they line up with state.
  always_comb begin
    grant_next = 4'b0000;
    sel_next   = sel_reg;
    valid_next = 1'b0;
    if (state_next == GRANT) begin
      grant_next = 4'b0001 << owner_next;
      sel_next   = owner_next;
      valid_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      owner_reg   <= 2'd0;
      lw_reg      <= 2'd3;
      cnt_reg     <= '0;
      grant_reg   <= 4'b0000;
      sel_reg     <= 2'd0;
      valid_reg   <= 1'b0;
      preempt_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      owner_reg   <= owner_next;
      lw_reg      <= lw_next;
      cnt_reg     <= cnt_next;
      grant_reg   <= grant_next;
      sel_reg     <= sel_next;
      valid_reg   <= valid_next;
      preempt_reg <= preempt_next;
    end
  end

  assign grant   = grant_reg;
  assign s1      = sel_reg[1];
  assign s0      = sel_reg[0];
  assign valid   = valid_reg;
  assign preempt = preempt_reg;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: a cycle model queues expected outputs per edge,
// directed sequences add fixed-value checks on the documented scenarios.
module tb_mux4_rr_arbiter;

  localparam int HOLD = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       done = 1'b0;
  logic [3:0] grant;
  logic       s1, s0, valid, preempt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [3:0] g;
    logic [1:0] s;
    logic       v;
    logic       p;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state: 0 idle, 1 grant, 2 gap.
  int         m_state = 0;
  int         m_owner = 0;
  int         m_lw = 3;
  int         m_cnt = 0;
  logic [1:0] m_sel = 2'd0;

  mux4_rr_arbiter #(.HOLD_MAX(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .grant(grant), .s1(s1), .s0(s0), .valid(valid), .preempt(preempt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int lw);
    for (int k = 1; k <= 4; k++) begin
      if (r[(lw + k) % 4]) return (lw + k) % 4;
    end
    return 0;
  endfunction

  task automatic model_edge(output exp_t e);
    logic pre;
    logic to;
    pre = 1'b0;
    if (!rst_n) begin
      m_state = 0; m_owner = 0; m_lw = 3; m_cnt = 0; m_sel = 2'd0;
    end else if (m_state == 1) begin
      to = (HOLD != 0) && (m_cnt == HOLD);
      if (done || !req[m_owner] || to) begin
        m_state = 2;
        pre = to && !done && req[m_owner];
      end else begin
        m_cnt++;
      end
    end else if (req != 4'b0000) begin
      m_owner = pick(req, m_lw);
      m_lw = m_owner;
      m_cnt = 1;
      m_state = 1;
    end else begin
      m_state = 0;
    end
    if (m_state == 1) m_sel = 2'(m_owner);
    e.g = (m_state == 1) ? (4'b0001 << m_owner) : 4'b0000;
    e.s = m_sel;
    e.v = (m_state == 1);
    e.p = pre;
  endtask

  // One clock: model predicts, DUT steps, prediction is popped and compared.
  task automatic step();
    exp_t e;
    exp_t got;
    model_edge(e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    got = exp_q.pop_front();
    check_eq("grant", {28'd0, grant}, {28'd0, got.g});
    check_eq("sel", {30'd0, s1, s0}, {30'd0, got.s});
    check_eq("valid", {31'd0, valid}, {31'd0, got.v});
    check_eq("preempt", {31'd0, preempt}, {31'd0, got.p});
    check_eq("onehot", {31'd0, $countones(grant) <= 1}, 32'd1);
    check_eq("grant_iff_valid", {31'd0, (grant != 4'b0000) == valid}, 32'd1);
    if (valid) check_eq("sel_is_owner", {28'd0, grant}, {28'd0, 4'b0001 << {s1, s0}});
    $display("cyc %0d rst_n=%b req=%b done=%b -> grant=%b sel=%0d valid=%b preempt=%b",
             cyc, rst_n, req, done, grant, {s1, s0}, valid, preempt);
  endtask

  task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] s,
                            input logic v, input logic p);
    check_eq({tag, ".grant"}, {28'd0, grant}, {28'd0, g});
    check_eq({tag, ".sel"}, {30'd0, s1, s0}, {30'd0, s});
    check_eq({tag, ".valid"}, {31'd0, valid}, {31'd0, v});
    check_eq({tag, ".preempt"}, {31'd0, preempt}, {31'd0, p});
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = 4'b0000; done = 1'b0;
    step();
    step();
    expect_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();

    // First request is granted one edge later.
    req = 4'b0001;
    step();
    expect_out("first_grant", 4'b0001, 2'd0, 1'b1, 1'b0);
    done = 1'b1; step(); done = 1'b0;
    req = 4'b0000; step();

    // All requesting with done each ownership: rotation 0,1,2,3,0 with gaps.
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      done = 1'b0; step();
      expect_out("rotate", 4'b0001 << (k % 4), 2'(k % 4), 1'b1, 1'b0);
      done = 1'b1; step();
      expect_out("rotate_gap", 4'b0000, 2'(k % 4), 1'b0, 1'b0);
    end
    done = 1'b0; req = 4'b0000; step();

    // Timeout: owner 0 holds for HOLD cycles, preempted, then input 2.
    do_reset();
    req = 4'b0101;
    for (int i = 0; i < HOLD; i++) begin
      step();
      expect_out("hold0", 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    step();
    expect_out("timeout_gap", 4'b0000, 2'd0, 1'b0, 1'b1);
    step();
    expect_out("after_timeout", 4'b0100, 2'd2, 1'b1, 1'b0);

    // Request drop: gap then idle with select held; done in idle ignored.
    req = 4'b0000;
    step();
    expect_out("drop_gap", 4'b0000, 2'd2, 1'b0, 1'b0);
    step();
    expect_out("idle_hold", 4'b0000, 2'd2, 1'b0, 1'b0);
    done = 1'b1; step(); done = 1'b0;
    expect_out("idle_done", 4'b0000, 2'd2, 1'b0, 1'b0);

    // Reset during a grant drops it immediately, no gap.
    req = 4'b0010;
    step();
    expect_out("owner1", 4'b0010, 2'd1, 1'b1, 1'b0);
    rst_n = 1'b0;
    step();
    expect_out("mid_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();
    expect_out("post_reset", 4'b0010, 2'd1, 1'b1, 1'b0);

    // Lone requester 3: regains after done, ignores non-owner churn, then times out.
    req = 4'b1000;
    step();
    expect_out("to3_gap", 4'b0000, 2'd1, 1'b0, 1'b0);
    step();
    expect_out("owner3", 4'b1000, 2'd3, 1'b1, 1'b0);
    done = 1'b1; step(); done = 1'b0;
    expect_out("done3_gap", 4'b0000, 2'd3, 1'b0, 1'b0);
    step();
    expect_out("regrant3", 4'b1000, 2'd3, 1'b1, 1'b0);
    req = 4'b1111; step();
    expect_out("churn_a", 4'b1000, 2'd3, 1'b1, 1'b0);
    req = 4'b1010; step();
    expect_out("churn_b", 4'b1000, 2'd3, 1'b1, 1'b0);
    req = 4'b1000;
    for (int i = 0; i < HOLD - 3; i++) step();
    expect_out("hold3_end", 4'b1000, 2'd3, 1'b1, 1'b0);
    step();
    expect_out("timeout3_gap", 4'b0000, 2'd3, 1'b0, 1'b1);
    step();
    expect_out("regain3", 4'b1000, 2'd3, 1'b1, 1'b0);

    // Random traffic checked only against the model.
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      done  = ($urandom_range(0, 7) == 0);
      rst_n = ($urandom_range(0, 40) != 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 SHALL have parameter: HOLD_MAX, default 8, maximum consecutive GRANT cycles per ownership; 0 disables the timeout.
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: req  input  4  request per mux input i0..i3 (bit n = input n).
REQ-005 SHALL have port: done  input  1  current owner releases the mux; sampled only in GRANT.
REQ-006 SHALL have port: grant  output  4  one-hot ownership, registered.
REQ-007 SHALL have port: s1  output  1  mux select MSB, registered.
REQ-008 SHALL have port: s0  output  1  mux select LSB, registered.
REQ-009 SHALL have port: valid  output  1  high when the mux output f belongs to the granted owner.
REQ-010 SHALL have port: preempt  output  1  one-cycle pulse on timeout release.

Function
REQ-011 SHALL implement states IDLE, GRANT, GAP; 2-bit owner index; 2-bit last-winner pointer lw; hold counter of width clog2(HOLD_MAX+1), minimum 1.
REQ-012 Arbitration SHALL search order lw+1, lw+2, lw+3, lw (mod 4); first set req bit wins.
REQ-013 IDLE: req==0 -> stay IDLE; req!=0 -> next edge enter GRANT with winner as owner, lw<=winner, counter<=1 (1-cycle request-to-grant latency).
REQ-014 GRANT: grant = one-hot(owner), {s1,s0} = owner, valid = 1.
REQ-015 GRANT exit to GAP at next edge when any of: done=1; req[owner]=0; HOLD_MAX!=0 and counter==HOLD_MAX; otherwise stay and counter increments (saturating).
REQ-016 preempt SHALL pulse high for exactly the GAP cycle following a timeout exit where done=0 and req[owner]=1; done or req drop on the same edge as timeout SHALL suppress preempt.
REQ-017 GAP: grant=0, valid=0, {s1,s0} held at previous owner (break-before-make); lasts exactly one cycle.
REQ-018 GAP exit: req!=0 -> GRANT with new winner per REQ-012 (lw already updated); req==0 -> IDLE.
REQ-019 Previous owner SHALL regain the mux after GAP only if no other req bit is set.
REQ-020 In IDLE {s1,s0} SHALL hold last value; grant=0, valid=0, preempt=0.
REQ-021 grant SHALL never have more than one bit set; grant!=0 iff valid=1.
REQ-022 req changes of non-owners during GRANT SHALL not affect grant, s1, s0.
REQ-023 done while in IDLE or GAP SHALL be ignored.

Reset
REQ-024 rst_n=0 at a rising edge SHALL force next cycle: state IDLE, grant=4'b0000, s1=0, s0=0, valid=0, preempt=0, lw=3, counter=0.
REQ-025 Reset asserted mid-GRANT SHALL drop grant and valid on the same edge with no GAP cycle; reset SHALL dominate all other inputs.
REQ-026 Outputs SHALL be deterministic from first edge with rst_n=0; no asynchronous paths.

Verification
REQ-027 Reset then req=4'b0001 -> one edge later grant=0001, {s1,s0}=00, valid=1.
REQ-028 req=4'b1111 held, done pulsed each ownership -> owners 0,1,2,3,0 in order, each GRANT separated by one GAP cycle with grant=0000.
REQ-029 HOLD_MAX=8, req=4'b0101, done=0 -> owner 0 for exactly 8 cycles, preempt=1 in following GAP, then grant=0100, {s1,s0}=10.
REQ-030 Owner 2 granted, req drops to 4'b0000 -> GAP, then IDLE with {s1,s0}=10 held, grant=0000.
REQ-031 Owner 1 granted, rst_n=0 for one edge -> grant=0000, {s1,s0}=00, valid=0; then req=4'b0010 -> grant=0010 one edge after rst_n=1.
REQ-032 Only req[3] set, done pulsed -> GAP then owner 3 re-granted, preempt=0 throughout; bench SHALL check one-hot grant and select==owner every cycle.
